// File: rtl/uart_rx_tx.sv
// Full-duplex UART: 2-flop synchronised receiver and transmitter with a CLKS_PER_BIT divider.
// Define UART_PARITY_EN to add an even-parity bit between the last data bit and the stop bit.
module uart_rx_tx #(
    parameter int unsigned CLKS_PER_BIT  = 217,
    parameter int unsigned NUM_DATA_BITS = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_rx,
    output logic                     o_rxStrobe,
    output logic                     o_rxErrorFlag,
    output logic [NUM_DATA_BITS-1:0] o_rxByte,
    input  logic                     i_txStart,
    input  logic [NUM_DATA_BITS-1:0] i_txByte,
    output logic                     o_tx,
    output logic                     o_txActive,
    output logic                     o_txDoneStrobe,
    output logic                     o_txErrorFlag
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(NUM_DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_DATA_BITS - 1);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

`ifdef UART_PARITY_EN
    localparam rx_state_t RX_AFTER_DATA = RX_PARITY;
    localparam tx_state_t TX_AFTER_DATA = TX_PARITY;
`else
    localparam rx_state_t RX_AFTER_DATA = RX_STOP;
    localparam tx_state_t TX_AFTER_DATA = TX_STOP;
`endif

    rx_state_t              rx_state;
    logic                   rx_meta;
    logic                   rx_sync;
    logic [CNT_W-1:0]       rx_cnt;
    logic [BIT_W-1:0]       rx_bit;
    logic [NUM_DATA_BITS-1:0] rx_shift;
    logic                   rx_par_ok;

    tx_state_t              tx_state;
    logic [CNT_W-1:0]       tx_cnt;
    logic [BIT_W-1:0]       tx_bit;
    logic [NUM_DATA_BITS-1:0] tx_shift;
    logic                   tx_parity;

    // Receiver: all sampling decisions are made on the synchronised line.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par_ok     <= 1'b1;
            o_rxStrobe    <= 1'b0;
            o_rxErrorFlag <= 1'b0;
            o_rxByte      <= '0;
        end else begin
            rx_meta    <= i_rx;
            rx_sync    <= rx_meta;
            o_rxStrobe <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state  <= RX_START;
                        rx_cnt    <= '0;
                        rx_par_ok <= 1'b1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[NUM_DATA_BITS-1:1]};
                        if (rx_bit == LAST_BIT) begin
                            rx_state <= RX_AFTER_DATA;
                        end else begin
                            rx_bit <= rx_bit + BIT_W'(1);
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt    <= '0;
                        rx_par_ok <= (rx_sync == ^rx_shift);
                        rx_state  <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt <= '0;
                        if (rx_sync && rx_par_ok) begin
                            o_rxByte      <= rx_shift;
                            o_rxStrobe    <= 1'b1;
                            o_rxErrorFlag <= 1'b0;
                            rx_state      <= RX_IDLE;
                        end else begin
                            o_rxErrorFlag <= 1'b1;
                            // A line still low here is a break: wait for idle before re-arming.
                            rx_state      <= rx_sync ? RX_IDLE : RX_WAIT_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Transmitter: o_txActive is high exactly while the FSM is outside TX_IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state       <= TX_IDLE;
            tx_cnt         <= '0;
            tx_bit         <= '0;
            tx_shift       <= '0;
            tx_parity      <= 1'b0;
            o_tx           <= 1'b1;
            o_txActive     <= 1'b0;
            o_txDoneStrobe <= 1'b0;
            o_txErrorFlag  <= 1'b0;
        end else begin
            o_txDoneStrobe <= 1'b0;
            if (i_txStart && o_txActive) begin
                o_txErrorFlag <= 1'b1;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (i_txStart) begin
                        tx_shift      <= i_txByte;
                        tx_parity     <= ^i_txByte;
                        tx_cnt        <= '0;
                        o_tx          <= 1'b0;
                        o_txActive    <= 1'b1;
                        o_txErrorFlag <= 1'b0;
                        tx_state      <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        o_tx     <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (tx_bit == LAST_BIT) begin
                            o_tx     <= (TX_AFTER_DATA == TX_PARITY) ? tx_parity : 1'b1;
                            tx_state <= TX_AFTER_DATA;
                        end else begin
                            tx_bit   <= tx_bit + BIT_W'(1);
                            tx_shift <= tx_shift >> 1;
                            o_tx     <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt   <= '0;
                        o_tx     <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt         <= '0;
                        o_tx           <= 1'b1;
                        o_txActive     <= 1'b0;
                        o_txDoneStrobe <= 1'b1;
                        tx_state       <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_tx.sv
// Bench for uart_rx_tx: frame-level TX/RX model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_rx_tx;
    localparam int CPB = 217;
    localparam int NB  = 8;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = NB + 3;
    localparam int EXP_ACTIVE = 2387;
`else
    localparam int FRAME_BITS = NB + 2;
    localparam int EXP_ACTIVE = 2170;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * CPB;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_rx;
    logic         i_txStart = 1'b0;
    logic [7:0]   i_txByte = 8'h00;
    logic         o_rxStrobe, o_rxErrorFlag, o_tx, o_txActive, o_txDoneStrobe, o_txErrorFlag;
    logic [7:0]   o_rxByte;

    logic         rx_drv = 1'b1;
    logic         loop_en = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    // Model state
    bit           model_on = 1'b0;
    int           tx_left = 0;
    logic [7:0]   tx_data = 8'h00;
    logic         tx_done = 1'b0;
    logic         tx_err = 1'b0;
    logic [7:0]   rx_last = 8'h00;
    logic [7:0]   rx_q[$];
    int           old_left;
    logic         exp_tx;
    logic [7:0]   exp_byte;

    // Observation counters
    int rx_strobes = 0;
    int done_cnt   = 0;
    int act_run    = 0;
    int last_run   = 0;
    int s0, d0;

    assign i_rx = loop_en ? (o_txActive ? o_tx : 1'b1) : rx_drv;

    uart_rx_tx #(.CLKS_PER_BIT(CPB), .NUM_DATA_BITS(NB)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx(i_rx),
        .o_rxStrobe(o_rxStrobe), .o_rxErrorFlag(o_rxErrorFlag), .o_rxByte(o_rxByte),
        .i_txStart(i_txStart), .i_txByte(i_txByte),
        .o_tx(o_tx), .o_txActive(o_txActive), .o_txDoneStrobe(o_txDoneStrobe),
        .o_txErrorFlag(o_txErrorFlag)
    );

    always #20 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level of serial bit position b of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= NB) return d[3'(b - 1)];
`ifdef UART_PARITY_EN
        if (b == NB + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Compare outputs against the model, then advance the model with the inputs of this cycle.
    always @(negedge i_clk) begin
        if (model_on) begin
            exp_tx = (tx_left > 0) ? frame_bit(tx_data, (FRAME_CLKS - tx_left) / CPB) : 1'b1;
            check("tx_line",   32'(o_tx),           32'(exp_tx));
            check("tx_active", 32'(o_txActive),     32'(tx_left > 0));
            check("tx_done",   32'(o_txDoneStrobe), 32'(tx_done));
            check("tx_err",    32'(o_txErrorFlag),  32'(tx_err));
            if (rx_q.size() == 0) begin
                check("rx_strobe_unexpected", 32'(o_rxStrobe), 32'(0));
                check("rx_byte_hold", 32'(o_rxByte), 32'(rx_last));
            end else if (o_rxStrobe === 1'b1) begin
                exp_byte = rx_q.pop_front();
                check("rx_byte_at_strobe", 32'(o_rxByte), 32'(exp_byte));
                rx_last = exp_byte;
            end else begin
                check("rx_byte_hold", 32'(o_rxByte), 32'(rx_last));
            end
        end
        if (o_txActive === 1'b1) act_run++;
        else if (act_run > 0) begin
            last_run = act_run;
            act_run  = 0;
        end
        if (o_txDoneStrobe === 1'b1) done_cnt++;
        if (o_rxStrobe === 1'b1) rx_strobes++;

        if (i_reset) begin
            model_on = 1'b1;
            tx_left  = 0;
            tx_done  = 1'b0;
            tx_err   = 1'b0;
            rx_last  = 8'h00;
            rx_q.delete();
        end else if (model_on) begin
            old_left = tx_left;
            tx_done  = (old_left == 1);
            if (old_left > 0) tx_left--;
            if (i_txStart) begin
                if (old_left == 0) begin
                    tx_left = FRAME_CLKS;
                    tx_data = i_txByte;
                    tx_err  = 1'b0;
                end else begin
                    tx_err = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    // Drive one serial frame; stop_low > 0 holds the stop bit low for that many bit times.
    task automatic rx_frame(input logic [7:0] d, input int start_clks, input int bit_clks,
                            input int stop_low);
        rx_drv = 1'b0;
        tick(start_clks);
        for (int i = 0; i < NB; i++) begin
            rx_drv = d[i];
            tick(bit_clks);
        end
`ifdef UART_PARITY_EN
        rx_drv = ^d;
        tick(bit_clks);
`endif
        if (stop_low > 0) begin
            rx_drv = 1'b0;
            tick(stop_low * bit_clks);
        end
        rx_drv = 1'b1;
        tick(bit_clks);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (o_txDoneStrobe !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        check("tx_done_timeout", 32'(o_txDoneStrobe), 32'(1));
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tick(4);
        i_reset = 1'b0;
        tick(1);
        check("rst_tx",      32'(o_tx),           32'(1));
        check("rst_active",  32'(o_txActive),     32'(0));
        check("rst_txerr",   32'(o_txErrorFlag),  32'(0));
        check("rst_rxerr",   32'(o_rxErrorFlag),  32'(0));
        check("rst_rxbyte",  32'(o_rxByte),       32'(0));
        check("rst_rxstb",   32'(o_rxStrobe),     32'(0));
        tick(5);

        // RX decode with slow start bit and fast data bits
        s0 = rx_strobes;
        rx_q.push_back(8'h37);
        rx_frame(8'h37, 240, 215, 0);
        tick(1);
        check("dec_strobes", 32'(rx_strobes - s0), 32'(1));
        check("dec_byte",    32'(o_rxByte),        32'(8'h37));
        check("dec_err",     32'(o_rxErrorFlag),   32'(0));
        check("dec_pending", 32'(rx_q.size()),     32'(0));

        // Loopback
        loop_en = 1'b1;
        tick(2);
        s0 = rx_strobes;
        d0 = done_cnt;
        rx_q.push_back(8'h3F);
        i_txStart = 1'b1;
        i_txByte  = 8'h3F;
        tick(1);
        i_txStart = 1'b0;
        i_txByte  = 8'h00;
        wait_done(3000);
        tick(3);
        check("lb_active_len", 32'(last_run),        32'(EXP_ACTIVE));
        check("lb_done_count", 32'(done_cnt - d0),   32'(1));
        check("lb_strobes",    32'(rx_strobes - s0), 32'(1));
        check("lb_byte",       32'(o_rxByte),        32'(8'h3F));

        // Framing error then recovery
        loop_en = 1'b0;
        tick(10);
        s0 = rx_strobes;
        rx_frame(8'hA5, CPB, CPB, 2);
        tick(CPB);
        check("ferr_flag",    32'(o_rxErrorFlag),   32'(1));
        check("ferr_byte",    32'(o_rxByte),        32'(8'h3F));
        check("ferr_strobes", 32'(rx_strobes - s0), 32'(0));
        rx_q.push_back(8'h5A);
        rx_frame(8'h5A, CPB, CPB, 0);
        tick(1);
        check("frec_flag",    32'(o_rxErrorFlag),   32'(0));
        check("frec_byte",    32'(o_rxByte),        32'(8'h5A));
        check("frec_strobes", 32'(rx_strobes - s0), 32'(1));

        // Glitch on idle line, then a normal frame
        s0 = rx_strobes;
        rx_drv = 1'b0;
        tick(50);
        rx_drv = 1'b1;
        tick(300);
        check("glitch_strobes", 32'(rx_strobes - s0), 32'(0));
        check("glitch_err",     32'(o_rxErrorFlag),   32'(0));
        rx_q.push_back(8'hC3);
        rx_frame(8'hC3, CPB, CPB, 0);
        tick(1);
        check("glitch_next_byte", 32'(o_rxByte),        32'(8'hC3));
        check("glitch_next_stb",  32'(rx_strobes - s0), 32'(1));

        // TX busy error and back-to-back start in the done cycle
        loop_en = 1'b1;
        tick(2);
        s0 = rx_strobes;
        rx_q.push_back(8'h3F);
        rx_q.push_back(8'h81);
        i_txStart = 1'b1;
        i_txByte  = 8'h3F;
        tick(1);
        i_txStart = 1'b0;
        i_txByte  = 8'hEE;
        tick(1000);
        i_txStart = 1'b1;
        i_txByte  = 8'h00;
        tick(1);
        i_txStart = 1'b0;
        tick(1);
        check("busy_err",    32'(o_txErrorFlag), 32'(1));
        check("busy_active", 32'(o_txActive),    32'(1));
        wait_done(2000);
        i_txStart = 1'b1;
        i_txByte  = 8'h81;
        tick(1);
        i_txStart = 1'b0;
        check("bb_err_clear", 32'(o_txErrorFlag), 32'(0));
        check("bb_active",    32'(o_txActive),    32'(1));
        wait_done(3000);
        tick(3);
        check("bb_strobes", 32'(rx_strobes - s0), 32'(2));
        check("bb_byte",    32'(o_rxByte),        32'(8'h81));

        // Reset in the middle of both frames, with both flags set beforehand
        loop_en = 1'b0;
        tick(5);
        rx_frame(8'h0F, CPB, CPB, 1);
        tick(CPB);
        check("pre_rst_rxerr", 32'(o_rxErrorFlag), 32'(1));
        s0 = rx_strobes;
        d0 = done_cnt;
        i_txStart = 1'b1;
        i_txByte  = 8'h55;
        rx_drv    = 1'b0;
        tick(1);
        i_txStart = 1'b0;
        tick(400);
        i_txStart = 1'b1;
        tick(1);
        i_txStart = 1'b0;
        tick(549);
        check("pre_rst_txerr", 32'(o_txErrorFlag), 32'(1));
        i_reset = 1'b1;
        rx_drv  = 1'b1;
        tick(1);
        i_reset = 1'b0;
        check("mid_rst_tx",     32'(o_tx),           32'(1));
        check("mid_rst_active", 32'(o_txActive),     32'(0));
        check("mid_rst_txerr",  32'(o_txErrorFlag),  32'(0));
        check("mid_rst_rxerr",  32'(o_rxErrorFlag),  32'(0));
        check("mid_rst_rxstb",  32'(o_rxStrobe),     32'(0));
        check("mid_rst_done",   32'(o_txDoneStrobe), 32'(0));
        tick(2500);
        check("post_rst_strobes", 32'(rx_strobes - s0), 32'(0));
        check("post_rst_done",    32'(done_cnt - d0),   32'(0));
        check("post_rst_rxerr",   32'(o_rxErrorFlag),   32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_tx.md
Name: uart_rx_tx

Overview:
- Full-duplex 8N1 UART block: an independent receiver path (UART_Rx function) and transmitter path (UART_Tx function) sharing one clock and reset.
- Baud rate is set by an integer clocks-per-bit divider.
- Sits between a board serial pin pair and the on-chip byte-level logic.
- Receiver delivers bytes with a one-cycle strobe; transmitter accepts bytes with a one-cycle start pulse.

Parameters:
- CLKS_PER_BIT, 217: clock cycles per serial bit (25 MHz / 115200 baud); legal values ≥ 4.
- NUM_DATA_BITS, 8: data bits per frame for both paths; legal range 5..8.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx  in  1  asynchronous serial input, idle high.
- o_rxStrobe  out  1  one-cycle pulse: new byte valid on o_rxByte.
- o_rxErrorFlag  out  1  receive framing/parity error, level.
- o_rxByte  out  NUM_DATA_BITS  last correctly received byte; held between frames.
- i_txStart  in  1  request to transmit i_txByte; sampled each cycle.
- i_txByte  in  NUM_DATA_BITS  byte to send; latched when a start is accepted.
- o_tx  out  1  serial output, idle high.
- o_txActive  out  1  high from the first cycle of the start bit through the last cycle of the stop bit.
- o_txDoneStrobe  out  1  one-cycle pulse when a frame completes.
- o_txErrorFlag  out  1  start requested while busy, level.

Behaviour:
- Interface decision: one clock (i_clk); reset i_reset is synchronous and active-high.
- Reset values:
  - o_tx=1; o_txActive, o_txDoneStrobe, o_txErrorFlag = 0.
  - o_rxStrobe, o_rxErrorFlag = 0; o_rxByte = 0.
  - Both FSMs go to IDLE and the RX synchronizer is set to 1.
- Reset mid-frame aborts the frame immediately, with no strobe and no flag.
- Frame format: start bit (0), NUM_DATA_BITS data bits LSB first, one stop bit (1).
- RX input conditioning: i_rx passes through a 2-flop synchronizer; all decisions use the synchronized value.
- RX FSM states IDLE, START, DATA, STOP, WAIT_IDLE; a bit counter drives the DATA state.
  - IDLE: on synchronized low, go to START and clear the counter.
  - START: after (CLKS_PER_BIT-1)/2 clocks (108 at default), sample the line. If low, go to DATA. If high, treat as a glitch and return to IDLE with no flag.
  - DATA: sample every CLKS_PER_BIT clocks (mid-bit); shift into bit index 0..NUM_DATA_BITS-1. After the last bit, go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - If high: load o_rxByte, pulse o_rxStrobe for exactly one cycle, clear o_rxErrorFlag, go to IDLE.
    - If low: set o_rxErrorFlag, leave o_rxByte unchanged, no strobe, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line is high, then go to IDLE (prevents a break from re-triggering).
- RX timing: o_rxStrobe and the new o_rxByte appear on the clock edge following the mid-stop-bit sample. They are valid well before the stop bit ends.
- RX bit-period tolerance: must decode frames whose bit period differs from CLKS_PER_BIT clocks by ±2%. The start bit may be stretched by up to half a bit.
- TX FSM states IDLE, START, DATA, STOP.
  - A start is accepted when i_txStart=1 and o_txActive=0.
  - On acceptance: latch i_txByte. On the next edge o_tx=0 and o_txActive=1.
  - Each bit is held exactly CLKS_PER_BIT clocks, so a full frame is (NUM_DATA_BITS+2)*CLKS_PER_BIT clocks.
  - After the stop bit: o_txActive=0, o_tx=1, and o_txDoneStrobe pulses for one cycle (the first idle cycle).
  - A start presented in that done cycle is accepted, giving back-to-back frames with no gap beyond one cycle.
- TX error: i_txStart=1 while o_txActive=1 is ignored.
  - The current frame is not disturbed.
  - o_txErrorFlag is set and stays set until the next accepted start or reset.
- i_txByte changes after acceptance have no effect on the frame in progress.
- RX and TX are fully independent. Loopback of o_tx to i_rx must work at any CLKS_PER_BIT.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - An even-parity bit is inserted between the last data bit and the stop bit on TX.
  - RX expects and checks that bit; a mismatch sets o_rxErrorFlag, suppresses o_rxStrobe, and leaves o_rxByte unchanged.
  - Frame length becomes (NUM_DATA_BITS+3)*CLKS_PER_BIT.
- Undefined: no parity bit, pure 8N1 as above.

Test Plan:
- RX decode: 40 ns clock, CLKS_PER_BIT=217. Drive 0x37 with 8600 ns bits and a 9600 ns start bit -> exactly one o_rxStrobe, o_rxByte=0x37, o_rxErrorFlag=0, one clock after the stop bit ends.
- Loopback: gate the line to o_tx when o_txActive else 1, feed it to i_rx, pulse i_txStart one cycle with i_txByte=0x3F -> o_rxStrobe rises with o_rxByte=0x3F. o_txActive is high for exactly 2170 clocks, then o_txDoneStrobe pulses once.
- Framing error: send 0xA5 with the stop bit held low for 2 bit times, then high -> o_rxErrorFlag=1, no strobe, o_rxByte keeps its previous value. A following good 0x5A gives a strobe, o_rxByte=0x5A, and the flag is cleared.
- Glitch: a 50-clock low pulse on idle i_rx -> no strobe, no error, and the RX FSM is back in IDLE.
- TX busy: re-pulse i_txStart with 0x00 at mid-frame of a 0x3F transmission -> o_txErrorFlag=1 and the frame still carries 0x3F. A start in the done cycle is accepted and the flag clears.
- Reset mid-frame: assert i_reset during TX data bit 3 and RX data bit 3 -> the next edge gives o_tx=1, o_txActive=0, no strobes, and both flags 0.
